// File: rtl/cfg_sender.sv
// rtl/cfg_sender.sv - table-driven configuration word sender
//
// Holds a DEPTH x DWIDTH table of configuration words. It can be written at any
// time. A start request streams the first `len` entries, in order, to a
// downstream receiver over a valid/busy handshake.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   tbl_addr   in   table write address
//   tbl_wreq   in   table write strobe
//   tbl_din    in   table write data
//   start      in   begin a send sequence (honoured only when idle)
//   start_len  in   number of words to send, clipped to DEPTH
//   abort      in   cancel the running sequence without a done pulse
//   busy       out  sequence in progress
//   done       out  one-cycle pulse after the last word is accepted
//   cfg_valid  out  cfg_data is offered to the receiver
//   cfg_busy   in   receiver cannot accept this cycle
//   cfg_data   out  offered configuration word

module cfg_sender #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] tbl_addr,
  input  logic              tbl_wreq,
  input  logic [DWIDTH-1:0] tbl_din,
  input  logic              start,
  input  logic [AWIDTH:0]   start_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              cfg_valid,
  input  logic              cfg_busy,
  output logic [DWIDTH-1:0] cfg_data
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0]   DEPTH_W = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0]   LEN_ONE = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH-1:0] IDX_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [AWIDTH:0]   len_q, len_d;
  logic [DWIDTH-1:0] data_q, data_d;

  // Configuration table. It is deliberately not reset, so the contents
  // survive a reset of the sequencer.
  logic [DWIDTH-1:0] tbl_q [DEPTH];

  logic [AWIDTH:0] len_clip;
  logic            last_word;
  logic            xfer;

  assign len_clip  = (start_len > DEPTH_W) ? DEPTH_W : start_len;
  // idx is widened by one bit so that idx+1 == len also works when len == DEPTH.
  assign last_word = (({1'b0, idx_q} + LEN_ONE) == len_q);
  assign xfer      = (state_q == S_SEND) && !cfg_busy;

  // A non-blocking table write makes a read of the same entry in the same
  // FETCH cycle return the old contents. Reset blocks the write.
  always_ff @(posedge clk) begin
    if (rst_n && tbl_wreq) begin
      tbl_q[tbl_addr] <= tbl_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        // abort is ignored here, so start always wins.
        if (start) begin
          len_d   = len_clip;
          idx_d   = '0;
          state_d = (len_clip == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          data_d  = tbl_q[idx_q];
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        // abort takes priority over a transfer in the same cycle. The
        // receiver still takes that word, but no done pulse follows.
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign cfg_valid = (state_q == S_SEND);
  assign cfg_data  = data_q;

endmodule

// File: tb/tb_cfg_sender.sv
// tb/tb_cfg_sender.sv - scoreboard testbench for cfg_sender

module tb_cfg_sender;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] tbl_addr;
  logic          tbl_wreq;
  logic [DW-1:0] tbl_din;
  logic          start;
  logic [AW:0]   start_len;
  logic          abort;
  logic          busy;
  logic          done;
  logic          cfg_valid;
  logic          cfg_busy;
  logic [DW-1:0] cfg_data;

  int checks   = 0;
  int errors   = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_w;
  logic [DW-1:0] tbl_m [DEPTH];

  cfg_sender #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tbl_addr  (tbl_addr),
    .tbl_wreq  (tbl_wreq),
    .tbl_din   (tbl_din),
    .start     (start),
    .start_len (start_len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .cfg_valid (cfg_valid),
    .cfg_busy  (cfg_busy),
    .cfg_data  (cfg_data)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted word is popped from exp_q and compared.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (cfg_valid === 1'b1 && cfg_busy === 1'b0) begin
      xfer_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got %h, required no transfer", cfg_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (cfg_data !== exp_w) begin
          errors++;
          $display("FAIL xfer_data: got %h, required %h", cfg_data, exp_w);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tbl(input int a, input logic [DW-1:0] d);
    tbl_addr = a[AW-1:0];
    tbl_din  = d;
    tbl_wreq = 1'b1;
    tick();
    tbl_wreq = 1'b0;
    tbl_m[a] = d;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(tbl_m[i]);
  endtask

  // Drives start for one cycle (cycle 0); returns in cycle 1.
  task automatic kick(input int n);
    start     = 1'b1;
    start_len = n[AW:0];
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tbl_wreq = 1'b0; tbl_addr = '0; tbl_din = '0;
    start = 1'b0; start_len = '0; abort = 1'b0; cfg_busy = 1'b0;
    repeat (3) tick();
    checks += 4;
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    if (cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", cfg_valid); end
    if (cfg_data !== '0)    begin errors++; $display("FAIL reset_data: got %h, required 0", cfg_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int x0;
    logic ev;
    write_tbl(0, 16'h1111);
    write_tbl(1, 16'h2222);
    write_tbl(2, 16'h3333);
    push_words(3);
    x0 = xfer_cnt;
    kick(3);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      ev = (c == 2 || c == 4 || c == 6);
      checks += 3;
      if (cfg_valid !== ev) begin errors++; $display("FAIL basic_valid c%0d: got %b, required %b", c, cfg_valid, ev); end
      if (done !== (c == 7)) begin errors++; $display("FAIL basic_done c%0d: got %b, required %b", c, done, (c == 7)); end
      if (busy !== (c < 8))  begin errors++; $display("FAIL basic_busy c%0d: got %b, required %b", c, busy, (c < 8)); end
    end
    checks++;
    if (xfer_cnt - x0 != 3) begin errors++; $display("FAIL basic_count: got %0d, required 3", xfer_cnt - x0); end
  endtask

  task automatic test_backpressure();
    int x0;
    push_words(3);
    x0 = xfer_cnt;
    kick(3);
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (c == 4) cfg_busy = 1'b1;
      if (c == 9) cfg_busy = 1'b0;
      if (c >= 4 && c <= 9) begin
        checks += 2;
        if (cfg_valid !== 1'b1)    begin errors++; $display("FAIL bp_valid c%0d: got %b, required 1", c, cfg_valid); end
        if (cfg_data !== 16'h2222) begin errors++; $display("FAIL bp_data c%0d: got %h, required 2222", c, cfg_data); end
      end
      if (c == 9) begin
        checks++;
        if (xfer_cnt - x0 != 1) begin errors++; $display("FAIL bp_stalled: got %0d xfers, required 1", xfer_cnt - x0); end
      end
      if (c == 10) begin
        checks += 2;
        if (xfer_cnt - x0 != 2) begin errors++; $display("FAIL bp_release: got %0d xfers, required 2", xfer_cnt - x0); end
        if (cfg_valid !== 1'b0) begin errors++; $display("FAIL bp_fetch: got %b, required 0", cfg_valid); end
      end
      if (c == 12) begin
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b, required 1", done); end
      end
    end
    wait_idle(20);
  endtask

  task automatic test_zero_len();
    int x0;
    int d0;
    x0 = xfer_cnt;
    d0 = done_cnt;
    kick(0);
    checks += 2;
    if (done !== 1'b1)      begin errors++; $display("FAIL zero_done: got %b, required 1", done); end
    if (cfg_valid !== 1'b0) begin errors++; $display("FAIL zero_valid: got %b, required 0", cfg_valid); end
    tick();
    checks += 3;
    if (busy !== 1'b0)      begin errors++; $display("FAIL zero_busy: got %b, required 0", busy); end
    if (xfer_cnt != x0)     begin errors++; $display("FAIL zero_xfers: got %0d, required 0", xfer_cnt - x0); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_pulses: got %0d, required 1", done_cnt - d0); end
  endtask

  task automatic test_oversize();
    int x0;
    int d0;
    for (int i = 0; i < DEPTH; i++) write_tbl(i, 16'hA000 + 16'(i * 16'h0111));
    push_words(DEPTH);
    x0 = xfer_cnt;
    d0 = done_cnt;
    kick(20);
    wait_idle(100);
    checks += 3;
    if (xfer_cnt - x0 != 16) begin errors++; $display("FAIL over_count: got %0d, required 16", xfer_cnt - x0); end
    if (done_cnt - d0 != 1)  begin errors++; $display("FAIL over_done: got %0d, required 1", done_cnt - d0); end
    if (exp_q.size() != 0)   begin errors++; $display("FAIL over_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    int d0;
    push_words(2);
    d0 = done_cnt;
    kick(3);
    tick(); tick(); tick();
    checks++;
    if (cfg_valid !== 1'b1) begin errors++; $display("FAIL abort_pre: got %b, required 1", cfg_valid); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks += 3;
    if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
    if (cfg_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b, required 0", cfg_valid); end
    if (done !== 1'b0)      begin errors++; $display("FAIL abort_done: got %b, required 0", done); end
    repeat (3) tick();
    checks += 2;
    if (done_cnt != d0)    begin errors++; $display("FAIL abort_nodone: got %0d pulses, required 0", done_cnt - d0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL abort_left: got %0d pending, required 0", exp_q.size()); end
    push_words(3);
    kick(3);
    wait_idle(20);
    checks += 2;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_restart_done: got %0d, required 1", done_cnt - d0); end
    if (exp_q.size() != 0)  begin errors++; $display("FAIL abort_restart_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_start_ignore();
    int x0;
    push_words(3);
    x0 = xfer_cnt;
    kick(3);
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (c == 2) begin start = 1'b1; start_len = 5'd1; end
      if (c == 4) start = 1'b0;
      if (c == 6 || c == 7 || c == 8) begin
        checks++;
        if (busy !== (c < 8)) begin errors++; $display("FAIL ign_busy c%0d: got %b, required %b", c, busy, (c < 8)); end
      end
      if (c == 7) begin
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b, required 1", done); end
      end
    end
    checks++;
    if (xfer_cnt - x0 != 3) begin errors++; $display("FAIL ign_count: got %0d, required 3", xfer_cnt - x0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    push_words(1);
    d0 = done_cnt;
    kick(3);
    tick(); tick(); tick();
    cfg_busy = 1'b1;
    rst_n    = 1'b0;
    tick();
    rst_n    = 1'b1;
    cfg_busy = 1'b0;
    checks += 4;
    if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL rmid_done: got %b, required 0", done); end
    if (cfg_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b, required 0", cfg_valid); end
    if (cfg_data !== '0)    begin errors++; $display("FAIL rmid_data: got %h, required 0", cfg_data); end
    repeat (3) tick();
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL rmid_nodone: got %0d, required 0", done_cnt - d0); end
    push_words(3);
    kick(3);
    wait_idle(20);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_collision();
    push_words(2);
    kick(2);
    tick(); tick();
    tbl_addr = 4'd1;
    tbl_din  = 16'hBEEF;
    tbl_wreq = 1'b1;
    tick();
    tbl_wreq = 1'b0;
    tbl_m[1] = 16'hBEEF;
    wait_idle(20);
    push_words(2);
    kick(2);
    wait_idle(20);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL coll_left: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_oversize();
    test_abort();
    test_start_ignore();
    test_reset_mid();
    test_collision();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_left: got %0d, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_sender.md
CFG_SENDER -- requirements
Module: cfg_sender

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: width of each config word.
REQ-002 SHALL have parameter AWIDTH, default 4: table address width; DEPTH = 2**AWIDTH entries.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tbl_addr  input  AWIDTH  table write address.
REQ-006 SHALL have port tbl_wreq  input  1  table write strobe.
REQ-007 SHALL have port tbl_din  input  DWIDTH  table write data.
REQ-008 SHALL have port start  input  1  begin a send sequence.
REQ-009 SHALL have port start_len  input  AWIDTH+1  number of words to send, sampled with start.
REQ-010 SHALL have port abort  input  1  cancel the running sequence.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at the end of a completed sequence.
REQ-013 SHALL have port cfg_valid  output  1  config word offered to the downstream receiver.
REQ-014 SHALL have port cfg_busy  input  1  downstream receiver cannot accept this cycle.
REQ-015 SHALL have port cfg_data  output  DWIDTH  offered config word.

Function
REQ-016 SHALL hold a DEPTH x DWIDTH table; tbl_wreq=1 writes tbl_din to tbl_addr at the clock edge in any state.
REQ-017 SHALL implement states IDLE, FETCH, SEND, DONE.
REQ-018 SHALL accept start only in IDLE and ignore start in every other state.
REQ-019 IDLE with start=1: SHALL latch len = min(start_len, DEPTH) and clear index idx to 0.
REQ-020 IDLE with start=1 and len=0: SHALL go to DONE with no cfg_valid cycles.
REQ-021 IDLE with start=1 and len>0: SHALL go to FETCH.
REQ-022 FETCH: SHALL register tbl[idx] into cfg_data and go to SEND next cycle; cfg_valid=0 in FETCH.
REQ-023 SEND: SHALL drive cfg_valid=1, with cfg_data stable, until a transfer occurs.
REQ-024 A transfer SHALL occur on a cycle with cfg_valid=1 and cfg_busy=0.
REQ-025 SEND with transfer and idx=len-1: SHALL go to DONE.
REQ-026 SEND with transfer and idx<len-1: SHALL increment idx and go to FETCH.
REQ-027 SEND with cfg_busy=1: SHALL stay in SEND with cfg_valid and cfg_data unchanged.
REQ-028 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-029 Throughput SHALL be at most one word per 2 cycles, i.e. one FETCH bubble per word.
REQ-030 Latency SHALL be exactly 2 cycles from start to the first cfg_valid, i.e. the start edge plus the FETCH cycle.
REQ-031 A table write to the address being read in the same FETCH cycle SHALL return the old contents (read-before-write).
REQ-032 abort=1 in FETCH, SEND or DONE SHALL force IDLE at the next edge, with cfg_valid=0 and done=0 from that edge.
REQ-033 abort SHALL take priority over a transfer in the same cycle; that word counts as transferred by the receiver, but the sequence ends without done.
REQ-034 abort=1 in IDLE SHALL have no effect; if start and abort are both high in IDLE, start SHALL win.
REQ-035 idx and len SHALL never wrap; idx ranges 0..DEPTH-1.

Reset
REQ-036 rst_n=0 at an edge SHALL force state IDLE and set busy=0, done=0, cfg_valid=0, cfg_data=0, idx=0, len=0.
REQ-037 Reset SHALL take priority over start, abort and the table write of the same cycle.
REQ-038 Table contents SHALL NOT be reset.
REQ-039 Reset asserted mid-sequence SHALL drop cfg_valid at that edge and produce no done pulse.

Verification
REQ-040 Bench SHALL run a basic send: write tbl[0..2]=0x1111,0x2222,0x3333, start with len=3, cfg_busy=0 -> cfg_valid high on cycles 2, 4, 6 carrying those values; done pulses on cycle 7; busy low on cycle 8.
REQ-041 Bench SHALL check backpressure: in the basic send, hold cfg_busy=1 for 5 cycles on word 2 -> cfg_valid stays high with cfg_data=0x2222 held stable, and the transfer occurs on the first cycle cfg_busy=0.
REQ-042 Bench SHALL check zero and oversize lengths: len=0 -> done pulses 1 cycle after start with no cfg_valid; len=20 with AWIDTH=4 -> exactly 16 transfers, tbl[0..15] in order.
REQ-043 Bench SHALL check abort: abort in SEND of word 1 of 3 -> IDLE next cycle, cfg_valid=0, no done; a new start then sends from tbl[0].
REQ-044 Bench SHALL check start-ignore and reset: start pulsed during SEND -> ignored, sequence unchanged; rst_n=0 mid-sequence -> all outputs 0 next cycle, table still readable with prior data.
REQ-045 Bench SHALL check the read-write collision: write 0xBEEF to tbl[1] in the FETCH cycle of word 1 -> old value sent; the next sequence sends 0xBEEF.
